// File: rtl/mips_cpu_run_monitor_if.sv
// Signal bundle between mips_cpu_run_monitor (slave) and the harness/CPU side (master).
// Defining MIPS_RUN_MONITOR_PAUSE_EN adds the pause input.
interface mips_cpu_run_monitor_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic             cpu_active;
    logic [WIDTH-1:0] register_v0;
`ifdef MIPS_RUN_MONITOR_PAUSE_EN
    logic             pause;
`endif
    logic             cpu_rst;
    logic             cpu_clk_enable;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail_mismatch;
    logic             fail_timeout;
    logic             fail_noactive;
    logic [CNT_W-1:0] cycle_count;
    logic [WIDTH-1:0] v0_captured;

    modport master (
`ifdef MIPS_RUN_MONITOR_PAUSE_EN
        output pause,
`endif
        output start, cpu_active, register_v0,
        input  cpu_rst, cpu_clk_enable, busy, done, pass,
        input  fail_mismatch, fail_timeout, fail_noactive, cycle_count, v0_captured
    );

    modport slave (
`ifdef MIPS_RUN_MONITOR_PAUSE_EN
        input  pause,
`endif
        input  start, cpu_active, register_v0,
        output cpu_rst, cpu_clk_enable, busy, done, pass,
        output fail_mismatch, fail_timeout, fail_noactive, cycle_count, v0_captured
    );
endinterface

// File: rtl/mips_cpu_run_monitor.sv
// Run controller for mips_cpu_harvard: sequences CPU reset, watchdogs the run, checks register_v0.
// Optional feature macro: MIPS_RUN_MONITOR_PAUSE_EN (adds pause, gating cpu_clk_enable in RUN).
module mips_cpu_run_monitor #(
    parameter int               WIDTH          = 32,
    parameter int               RESET_CYCLES   = 2,
    parameter int               TIMEOUT_CYCLES = 1000,
    parameter int               CNT_W          = 16,
    parameter logic [WIDTH-1:0] EXPECTED_V0    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_cpu_run_monitor_if.slave bus
);
    localparam int               RST_W     = $clog2(RESET_CYCLES + 1);
    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_WAIT_ACTIVE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [RST_W-1:0] r_rst_cnt;
    logic             r_cpu_rst;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_fail_mismatch;
    logic             r_fail_timeout;
    logic             r_fail_noactive;
    logic [CNT_W-1:0] r_cycle_count;
    logic [WIDTH-1:0] r_v0_captured;

    logic             w_run_tick;
    logic [CNT_W-1:0] w_count_next;
    logic             w_v0_match;

    // A run cycle only counts when the CPU is actually clocked.
`ifdef MIPS_RUN_MONITOR_PAUSE_EN
    assign w_run_tick         = (r_state == S_RUN) && !bus.pause;
    assign bus.cpu_clk_enable = !((r_state == S_RUN) && bus.pause);
`else
    assign w_run_tick         = (r_state == S_RUN);
    assign bus.cpu_clk_enable = 1'b1;
`endif

    assign w_count_next = r_cycle_count + CNT_W'(1);
    assign w_v0_match   = (bus.register_v0 == EXPECTED_V0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_rst_cnt       <= '0;
            r_cpu_rst       <= 1'b1;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_fail_mismatch <= 1'b0;
            r_fail_timeout  <= 1'b0;
            r_fail_noactive <= 1'b0;
            r_cycle_count   <= '0;
            r_v0_captured   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state         <= S_RESET;
                        r_rst_cnt       <= '0;
                        r_cpu_rst       <= 1'b1;
                        r_busy          <= 1'b1;
                        r_done          <= 1'b0;
                        r_pass          <= 1'b0;
                        r_fail_mismatch <= 1'b0;
                        r_fail_timeout  <= 1'b0;
                        r_fail_noactive <= 1'b0;
                        r_cycle_count   <= '0;
                        r_v0_captured   <= '0;
                    end
                end
                S_RESET: begin
                    if (r_rst_cnt == RST_LAST) begin
                        r_state   <= S_WAIT_ACTIVE;
                        r_cpu_rst <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RST_W'(1);
                    end
                end
                S_WAIT_ACTIVE: begin
                    if (bus.cpu_active) begin
                        r_state <= S_RUN;
                    end else begin
                        r_state         <= S_DONE;
                        r_busy          <= 1'b0;
                        r_done          <= 1'b1;
                        r_fail_noactive <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_run_tick) begin
                        r_cycle_count <= w_count_next;
                    end
                    // Completion is tested first so a halt on the last allowed cycle still gets checked.
                    if (!bus.cpu_active) begin
                        r_state         <= S_DONE;
                        r_busy          <= 1'b0;
                        r_done          <= 1'b1;
                        r_v0_captured   <= bus.register_v0;
                        r_pass          <= w_v0_match;
                        r_fail_mismatch <= !w_v0_match;
                    end else if (w_run_tick && (w_count_next == CNT_LIMIT)) begin
                        r_state        <= S_DONE;
                        r_busy         <= 1'b0;
                        r_done         <= 1'b1;
                        r_fail_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_rst       = r_cpu_rst;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.pass          = r_pass;
    assign bus.fail_mismatch = r_fail_mismatch;
    assign bus.fail_timeout  = r_fail_timeout;
    assign bus.fail_noactive = r_fail_noactive;
    assign bus.cycle_count   = r_cycle_count;
    assign bus.v0_captured   = r_v0_captured;
endmodule

// File: tb/tb_mips_cpu_run_monitor.sv
// Randomized bench for mips_cpu_run_monitor: a simple CPU stand-in plus a run-level reference model
// that predicts every output each cycle; directed runs pin the model with literal expectations.
`timescale 1ns/1ps
module tb_mips_cpu_run_monitor;
    localparam int               WIDTH  = 32;
    localparam int               RC     = 3;
    localparam int               TO     = 100;
    localparam int               CNT_W  = 8;
    localparam logic [WIDTH-1:0] EXP_V0 = '0;
`ifdef MIPS_RUN_MONITOR_PAUSE_EN
    localparam bit HAS_PAUSE = 1'b1;
`else
    localparam bit HAS_PAUSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_cpu_run_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    mips_cpu_run_monitor #(
        .WIDTH(WIDTH), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W), .EXPECTED_V0(EXP_V0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Plan for the run being launched (written by the main sequence only).
    bit          p_noact = 1'b0;
    int          p_len   = 1;
    logic [31:0] p_v0    = '0;
    int          p_pmode = 0;

    logic pause_drv = 1'b0;
`ifdef MIPS_RUN_MONITOR_PAUSE_EN
    assign bus.pause = pause_drv;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    // Flag byte order: cpu_rst, cpu_clk_enable, busy, done, pass, fail_mismatch, fail_timeout, fail_noactive
    function automatic logic [63:0] lit(input logic [7:0] f, input int cnt, input logic [31:0] v);
        return {16'h0, f, CNT_W'(cnt), v};
    endfunction

    function automatic logic [63:0] act_vec();
        return {16'h0, bus.cpu_rst, bus.cpu_clk_enable, bus.busy, bus.done, bus.pass,
                bus.fail_mismatch, bus.fail_timeout, bus.fail_noactive, bus.cycle_count, bus.v0_captured};
    endfunction

    // CPU stand-in: active comes up right after reset release, drops after p_len clocked cycles.
    bit cpu_en_q = 1'b1;
    always @(negedge clk) cpu_en_q = bus.cpu_clk_enable;

    int cpu_k   = -1;
    int win_used = 0;
    initial begin
        bus.cpu_active  = 1'b0;
        bus.register_v0 = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.cpu_rst) begin
                bus.cpu_active  = 1'b0;
                bus.register_v0 = $urandom;
                cpu_k           = -1;
                win_used        = 0;
            end else if (cpu_k < 0) begin
                cpu_k          = 0;
                bus.cpu_active = !p_noact;
            end else if (bus.cpu_active && cpu_en_q) begin
                cpu_k++;
                if (cpu_k == p_len) begin
                    bus.cpu_active  = 1'b0;
                    bus.register_v0 = p_v0;
                end else begin
                    bus.register_v0 = $urandom;
                end
            end
            pause_drv = 1'b0;
            if (HAS_PAUSE && bus.cpu_active && cpu_k >= 1) begin
                if (p_pmode == 1) begin
                    pause_drv = ($urandom_range(0, 3) == 0);
                end else if (p_pmode == 2 && cpu_k >= 20 && win_used < 10) begin
                    pause_drv = 1'b1;
                    win_used++;
                end
            end
        end
    end

    // Reference model: phase 0 idle, 1 busy, 2 done; m_t = edges since accepted start,
    // m_ticks = clocked run cycles; outcome follows from the latched plan.
    int          m_phase = 0;
    int          m_t     = 0;
    int          m_ticks = 0;
    int          m_len   = 1;
    bit          m_noact = 1'b0;
    logic [31:0] m_v0    = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0;
            m_t     = 0;
            m_ticks = 0;
        end else if (m_phase != 1) begin
            if (bus.start) begin
                m_phase = 1;
                m_t     = 0;
                m_ticks = 0;
                m_noact = p_noact;
                m_len   = p_len;
                m_v0    = p_v0;
            end
        end else begin
            m_t++;
            if (m_t == RC + 1) begin
                if (m_noact) m_phase = 2;
            end else if (m_t > RC + 1) begin
                if (!pause_drv) m_ticks++;
                if (m_ticks == ((m_len <= TO) ? m_len : TO)) m_phase = 2;
            end
        end
    end

    function automatic logic [63:0] exp_vec();
        logic [7:0]  f;
        int          cnt;
        logic [31:0] v;
        bit          in_run;
        f      = '0;
        cnt    = 0;
        v      = '0;
        in_run = (m_phase == 1) && (m_t >= RC + 1);
        f[6]   = !(HAS_PAUSE && in_run && pause_drv);
        if (m_phase == 0) begin
            f[7] = 1'b1;
        end else if (m_phase == 1) begin
            f[7] = (m_t < RC);
            f[5] = 1'b1;
            cnt  = m_ticks;
        end else begin
            f[4] = 1'b1;
            if (m_noact) begin
                f[0] = 1'b1;
            end else if (m_len <= TO) begin
                cnt = m_len;
                v   = m_v0;
                if (m_v0 == EXP_V0) f[3] = 1'b1;
                else f[2] = 1'b1;
            end else begin
                cnt  = TO;
                f[1] = 1'b1;
            end
        end
        return lit(f, cnt, v);
    endfunction

    always @(negedge clk) chk("cycle", act_vec(), exp_vec());

    int en_low_cnt = 0;
    always @(negedge clk) if (!bus.cpu_clk_enable) en_low_cnt++;

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic do_run(input bit noact, input int len, input logic [31:0] v0, input int pm,
                          input int spur_at, input int rst_at, output int lat, output bit aborted);
        int edges;
        bit seen;
        p_noact    = noact;
        p_len      = len;
        p_v0       = v0;
        p_pmode    = pm;
        en_low_cnt = 0;
        bus.start  = 1'b1;
        edges      = 0;
        seen       = 1'b0;
        aborted    = 1'b0;
        while (!seen && edges < 400) begin
            @(posedge clk);
            edges++;
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                seen = 1'b1;
            end else if (rst_at != 0 && edges == rst_at) begin
                #2 rst = 1'b0;
                #1 chk("async_rst", act_vec(), lit(8'b1100_0000, 0, 0));
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                aborted = 1'b1;
                seen    = 1'b1;
            end else if (spur_at != 0 && edges == spur_at) begin
                bus.start = 1'b1;
            end
        end
        if (!seen) chk("done_wait", 64'd0, 64'd1);
        lat = edges;
        $display("run noact=%0d len=%0d v0=%h pmode=%0d spur=%0d rst_at=%0d -> done=%0d pass=%0d mm=%0d to=%0d na=%0d count=%0d v0c=%h lat=%0d aborted=%0d",
                 noact, len, v0, pm, spur_at, rst_at, bus.done, bus.pass, bus.fail_mismatch,
                 bus.fail_timeout, bus.fail_noactive, bus.cycle_count, bus.v0_captured, lat, aborted);
    endtask

    initial begin
        int lat;
        bit ab;
        bus.start = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", act_vec(), lit(8'b1100_0000, 0, 0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("idle_after_release", act_vec(), lit(8'b1100_0000, 0, 0));
        @(posedge clk);
        #1;

        do_run(1'b0, 50, 32'h0, 0, 0, 0, lat, ab);
        chk("pass_run", act_vec(), lit(8'b0101_1000, 50, 0));

        do_run(1'b0, 50, 32'h7, 0, 0, 0, lat, ab);
        chk("mismatch_run", act_vec(), lit(8'b0101_0100, 50, 32'h7));

        do_run(1'b0, 200, 32'h0, 0, 0, 0, lat, ab);
        chk("timeout_run", act_vec(), lit(8'b0101_0010, TO, 0));
        chk("timeout_active", 64'(bus.cpu_active), 64'd1);

        do_run(1'b1, 50, 32'h0, 0, 0, 0, lat, ab);
        chk("noactive_run", act_vec(), lit(8'b0101_0001, 0, 0));
        chk("noactive_latency", 64'(lat), 64'(RC + 2));

        do_run(1'b0, 60, 32'h0, 0, 0, RC + 22, lat, ab);
        chk("rst_abort", 64'(ab), 64'd1);
        do_run(1'b0, 30, 32'h0, 0, 0, 0, lat, ab);
        chk("fresh_run", act_vec(), lit(8'b0101_1000, 30, 0));

        do_run(1'b0, 40, 32'h0, 0, 10, 0, lat, ab);
        chk("spurious_start", act_vec(), lit(8'b0101_1000, 40, 0));

        do_run(1'b0, TO, 32'h5, 0, 0, 0, lat, ab);
        chk("halt_at_limit", act_vec(), lit(8'b0101_0100, TO, 32'h5));
        do_run(1'b0, TO + 1, 32'h0, 0, 0, 0, lat, ab);
        chk("limit_plus_one", act_vec(), lit(8'b0101_0010, TO, 0));

        if (HAS_PAUSE) begin
            do_run(1'b0, 50, 32'h0, 2, 0, 0, lat, ab);
            chk("pause_run", act_vec(), lit(8'b0101_1000, 50, 0));
            chk("pause_en_low", 64'(en_low_cnt), 64'd10);
        end

        for (int r = 0; r < 16; r++) begin
            bit          noact;
            int          len;
            logic [31:0] v0;
            int          pm;
            int          spur;
            int          rat;
            noact = ($urandom_range(0, 5) == 0);
            len   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TO - 2, TO + 20)) : int'($urandom_range(1, 80));
            v0    = ($urandom_range(0, 1) == 1) ? 32'h0 : $urandom;
            pm    = HAS_PAUSE ? int'($urandom_range(0, 1)) : 0;
            spur  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 0;
            rat   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 30)) : 0;
            do_run(noact, len, v0, pm, spur, rat, lat, ab);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
